// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_pkg
//  Description : Shared SHA-256 constants (initial hash value), FSM state
//                encoding and a 32-bit rotate helper for the round core.
//  Revision    : 1.0  initial release
// ============================================================================
package sha256_pkg;

  // Standard SHA-256 initial hash value, H0 in the top word.
  localparam logic [255:0] c_iv = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Round-core control states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ROUND = 3'd4,
    ST_FINAL = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Rotate right by a constant amount (1..31).
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage : sha256_pkg
`default_nettype wire

// File: rtl/sha256_k_rom.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_k_rom
//  Description : Combinational lookup of the 64 SHA-256 round constants K[t].
//  Revision    : 1.0  initial release
// ============================================================================
module sha256_k_rom (
  input  logic [5:0]  i_addr,
  output logic [31:0] o_k
);

  // Constant table indexed by round number.
  always_comb begin
    o_k = 32'h0;
    unique case (i_addr)
      6'd0:  o_k = 32'h428a2f98;  6'd1:  o_k = 32'h71374491;
      6'd2:  o_k = 32'hb5c0fbcf;  6'd3:  o_k = 32'he9b5dba5;
      6'd4:  o_k = 32'h3956c25b;  6'd5:  o_k = 32'h59f111f1;
      6'd6:  o_k = 32'h923f82a4;  6'd7:  o_k = 32'hab1c5ed5;
      6'd8:  o_k = 32'hd807aa98;  6'd9:  o_k = 32'h12835b01;
      6'd10: o_k = 32'h243185be;  6'd11: o_k = 32'h550c7dc3;
      6'd12: o_k = 32'h72be5d74;  6'd13: o_k = 32'h80deb1fe;
      6'd14: o_k = 32'h9bdc06a7;  6'd15: o_k = 32'hc19bf174;
      6'd16: o_k = 32'he49b69c1;  6'd17: o_k = 32'hefbe4786;
      6'd18: o_k = 32'h0fc19dc6;  6'd19: o_k = 32'h240ca1cc;
      6'd20: o_k = 32'h2de92c6f;  6'd21: o_k = 32'h4a7484aa;
      6'd22: o_k = 32'h5cb0a9dc;  6'd23: o_k = 32'h76f988da;
      6'd24: o_k = 32'h983e5152;  6'd25: o_k = 32'ha831c66d;
      6'd26: o_k = 32'hb00327c8;  6'd27: o_k = 32'hbf597fc7;
      6'd28: o_k = 32'hc6e00bf3;  6'd29: o_k = 32'hd5a79147;
      6'd30: o_k = 32'h06ca6351;  6'd31: o_k = 32'h14292967;
      6'd32: o_k = 32'h27b70a85;  6'd33: o_k = 32'h2e1b2138;
      6'd34: o_k = 32'h4d2c6dfc;  6'd35: o_k = 32'h53380d13;
      6'd36: o_k = 32'h650a7354;  6'd37: o_k = 32'h766a0abb;
      6'd38: o_k = 32'h81c2c92e;  6'd39: o_k = 32'h92722c85;
      6'd40: o_k = 32'ha2bfe8a1;  6'd41: o_k = 32'ha81a664b;
      6'd42: o_k = 32'hc24b8b70;  6'd43: o_k = 32'hc76c51a3;
      6'd44: o_k = 32'hd192e819;  6'd45: o_k = 32'hd6990624;
      6'd46: o_k = 32'hf40e3585;  6'd47: o_k = 32'h106aa070;
      6'd48: o_k = 32'h19a4c116;  6'd49: o_k = 32'h1e376c08;
      6'd50: o_k = 32'h2748774c;  6'd51: o_k = 32'h34b0bcb5;
      6'd52: o_k = 32'h391c0cb3;  6'd53: o_k = 32'h4ed8aa4a;
      6'd54: o_k = 32'h5b9cca4f;  6'd55: o_k = 32'h682e6ff3;
      6'd56: o_k = 32'h748f82ee;  6'd57: o_k = 32'h78a5636f;
      6'd58: o_k = 32'h84c87814;  6'd59: o_k = 32'h8cc70208;
      6'd60: o_k = 32'h90befffa;  6'd61: o_k = 32'ha4506ceb;
      6'd62: o_k = 32'hbef9a3f7;  6'd63: o_k = 32'hc67178f2;
      default: o_k = 32'h0;
    endcase
  end

endmodule : sha256_k_rom
`default_nettype wire

// File: rtl/sha256_round_core.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_round_core
//  Description : SHA-256 compression stage. Fetches W[0..63] one word at a
//                time from the schedule generator, runs 64 rounds on a..h and
//                accumulates the result into the chaining state H0..H7.
//  Revision    : 1.0  initial release
// ============================================================================
module sha256_round_core
  import sha256_pkg::*;
#(
  parameter int W_LAT = 2   // read-to-data latency of the W generator, 2..7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         first_block,
  input  logic         w_reg_rdy,
  input  logic [31:0]  w_reg_data,
  output logic         w_reg_read,
  output logic [5:0]   w_reg_addr,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  localparam logic [2:0] c_wait_last = 3'(W_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_round;
  logic [2:0]  r_wait;
  logic        r_first;
  logic [31:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [31:0] r_hv [8];

  logic [31:0] w_k;
  logic [31:0] w_sig0, w_sig1, w_ch, w_maj, w_t1, w_t2;

  sha256_k_rom u_k_rom (
    .i_addr (r_round),
    .o_k    (w_k)
  );

  // Round function terms for the current working registers.
  assign w_sig0 = rotr(r_a, 2) ^ rotr(r_a, 13) ^ rotr(r_a, 22);
  assign w_sig1 = rotr(r_e, 6) ^ rotr(r_e, 11) ^ rotr(r_e, 25);
  assign w_ch   = (r_e & r_f) ^ (~r_e & r_g);
  assign w_maj  = (r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c);
  assign w_t1   = r_h + w_sig1 + w_ch + w_k + w_reg_data;
  assign w_t2   = w_sig0 + w_maj;

  // The requested word index is the round counter itself; it holds between requests.
  assign w_reg_addr = r_round;
  assign digest     = {r_hv[0], r_hv[1], r_hv[2], r_hv[3],
                       r_hv[4], r_hv[5], r_hv[6], r_hv[7]};

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_next     = r_state;
    w_reg_read = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (start) w_next = ST_LOAD;
      ST_LOAD: begin
        busy   = 1'b1;
        w_next = ST_REQ;
      end
      ST_REQ: begin
        busy = 1'b1;
        if (w_reg_rdy) begin
          w_reg_read = 1'b1;
          w_next     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (r_wait == c_wait_last) w_next = ST_ROUND;
      end
      ST_ROUND: begin
        busy   = 1'b1;
        w_next = (r_round == 6'd63) ? ST_FINAL : ST_REQ;
      end
      ST_FINAL: begin
        busy   = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (!start) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Counters, working registers and chaining state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_round <= 6'd0;
      r_wait  <= 3'd0;
      r_first <= 1'b0;
      r_a <= 32'h0; r_b <= 32'h0; r_c <= 32'h0; r_d <= 32'h0;
      r_e <= 32'h0; r_f <= 32'h0; r_g <= 32'h0; r_h <= 32'h0;
      for (int i = 0; i < 8; i++) r_hv[i] <= 32'h0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (start) r_first <= first_block;
        ST_LOAD: begin
          r_round <= 6'd0;
          r_wait  <= 3'd0;
          if (r_first) begin
            for (int i = 0; i < 8; i++) r_hv[i] <= c_iv[255-32*i -: 32];
            {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= c_iv;
          end else begin
            {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= digest;
          end
        end
        ST_WAIT: begin
          if (r_wait == c_wait_last) r_wait <= 3'd0;
          else                       r_wait <= r_wait + 3'd1;
        end
        ST_ROUND: begin
          r_h <= r_g;
          r_g <= r_f;
          r_f <= r_e;
          r_e <= r_d + w_t1;
          r_d <= r_c;
          r_c <= r_b;
          r_b <= r_a;
          r_a <= w_t1 + w_t2;
          if (r_round != 6'd63) r_round <= r_round + 6'd1;
        end
        ST_FINAL: begin
          r_hv[0] <= r_hv[0] + r_a;
          r_hv[1] <= r_hv[1] + r_b;
          r_hv[2] <= r_hv[2] + r_c;
          r_hv[3] <= r_hv[3] + r_d;
          r_hv[4] <= r_hv[4] + r_e;
          r_hv[5] <= r_hv[5] + r_f;
          r_hv[6] <= r_hv[6] + r_g;
          r_hv[7] <= r_hv[7] + r_h;
        end
        ST_DONE: if (!start) r_first <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule : sha256_round_core
`default_nettype wire

// File: tb/tb_sha256_round_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_round_core
//  Description : Directed self-checking bench for sha256_round_core with a
//                behavioural W-schedule generator attached.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sha256_round_core;

  localparam int W_LAT = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         first_block = 1'b0;
  logic         w_reg_rdy = 1'b1;
  logic [31:0]  w_reg_data = 32'h0;
  logic         w_reg_read;
  logic [5:0]   w_reg_addr;
  logic         busy;
  logic         done;
  logic [255:0] digest;

  int errors = 0;
  int checks = 0;

  sha256_round_core #(.W_LAT(W_LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .first_block (first_block),
    .w_reg_rdy   (w_reg_rdy),
    .w_reg_data  (w_reg_data),
    .w_reg_read  (w_reg_read),
    .w_reg_addr  (w_reg_addr),
    .busy        (busy),
    .done        (done),
    .digest      (digest)
  );

  always #5 clock = ~clock;

  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

  // ---------------- W generator model ----------------
  logic [31:0] wsched [64];
  int          gen_cnt = 0;
  logic [5:0]  gen_addr = 6'd0;
  logic        rd_pend = 1'b0;
  logic [5:0]  rd_pend_addr = 6'd0;

  int          rd_count = 0;
  int          rd_bad_addr = 0;
  int          rd_low_rdy = 0;
  logic [5:0]  rd_expect = 6'd0;

  function automatic logic [31:0] rr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic load_block(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) wsched[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      wsched[t] = ss1(wsched[t-2]) + wsched[t-7] + ss0(wsched[t-15]) + wsched[t-16];
  endtask

  // Read-pulse monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (w_reg_read === 1'b1) begin
      rd_pend      = 1'b1;
      rd_pend_addr = w_reg_addr;
      rd_count++;
      if (w_reg_addr !== rd_expect) rd_bad_addr++;
      rd_expect = rd_expect + 6'd1;
      if (w_reg_rdy !== 1'b1) rd_low_rdy++;
    end
  end

  // Generator response: garbage right after the request, valid W_LAT cycles after it.
  always @(posedge clock) begin
    #1;
    if (rd_pend) begin
      rd_pend    = 1'b0;
      gen_addr   = rd_pend_addr;
      gen_cnt    = W_LAT - 1;
      w_reg_data = 32'hdeadbeef;
    end else if (gen_cnt > 0) begin
      gen_cnt--;
      if (gen_cnt == 0) w_reg_data = wsched[gen_addr];
    end
  end

  task automatic clear_monitor();
    rd_count    = 0;
    rd_bad_addr = 0;
    rd_low_rdy  = 0;
    rd_expect   = 6'd0;
    rd_pend     = 1'b0;
    gen_cnt     = 0;
  endtask

  function automatic logic rdy_for(input int n, input int pre, input int rnd, input int len);
    if (n >= 1 && n <= pre) return 1'b0;
    if (len > 0 && n >= pre + 1 + 4*rnd && n < pre + 1 + 4*rnd + len) return 1'b0;
    return 1'b1;
  endfunction

  // Runs one block from IDLE; done_edge counts edges after the start-sampling edge.
  task automatic run_block(input logic first, input int pre, input int rnd, input int len,
                           output int done_edge, output logic busy_at1);
    int n;
    clear_monitor();
    @(negedge clock);
    first_block = first;
    start       = 1'b1;
    w_reg_rdy   = 1'b1;
    @(posedge clock);
    #1;
    n = 0;
    w_reg_rdy = rdy_for(n, pre, rnd, len);
    done_edge = -1;
    busy_at1  = 1'b0;
    while (n < 2000) begin
      @(posedge clock);
      #1;
      n++;
      w_reg_rdy = rdy_for(n, pre, rnd, len);
      if (n == 1) busy_at1 = busy;
      if (done === 1'b1) begin
        done_edge = n;
        break;
      end
    end
    @(negedge clock);
    start     = 1'b0;
    w_reg_rdy = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    #12;
    reset = 1'b1;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (w_reg_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b want 0", w_reg_read); end
    checks++; if (w_reg_addr !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", w_reg_addr); end
    checks++; if (digest !== 256'h0) begin errors++; $display("FAIL reset_digest: got %h want 0", digest); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_abc();
    int de; logic b1;
    load_block(BLK_ABC);
    run_block(1'b1, 0, 0, 0, de, b1);
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL abc_busy_edge1: got %b want 1", b1); end
    checks++; if (de != 258) begin errors++; $display("FAIL abc_done_edge: got %0d want 258", de); end
    checks++; if (digest !== DIG_ABC) begin errors++; $display("FAIL abc_digest: got %h want %h", digest, DIG_ABC); end
    checks++; if (rd_count != 64) begin errors++; $display("FAIL abc_read_count: got %0d want 64", rd_count); end
    checks++; if (rd_bad_addr != 0) begin errors++; $display("FAIL abc_read_order: got %0d bad addresses want 0", rd_bad_addr); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abc_back_idle: got done=%b busy=%b want 0/0", done, busy); end
    checks++; if (digest !== DIG_ABC) begin errors++; $display("FAIL abc_digest_hold: got %h want %h", digest, DIG_ABC); end
  endtask

  task automatic test_empty();
    int de; logic b1;
    load_block(BLK_EMPTY);
    run_block(1'b1, 0, 0, 0, de, b1);
    checks++; if (digest !== DIG_EMPTY) begin errors++; $display("FAIL empty_digest: got %h want %h", digest, DIG_EMPTY); end
    checks++; if (de != 258) begin errors++; $display("FAIL empty_done_edge: got %0d want 258", de); end
  endtask

  task automatic test_two_block();
    int de1, de2; logic b1;
    load_block(BLK_TWO1);
    run_block(1'b1, 0, 0, 0, de1, b1);
    load_block(BLK_TWO2);
    run_block(1'b0, 0, 0, 0, de2, b1);
    checks++; if (de1 != 258 || de2 != 258) begin errors++; $display("FAIL two_done_edges: got %0d/%0d want 258/258", de1, de2); end
    checks++; if (digest !== DIG_TWO) begin errors++; $display("FAIL two_digest: got %h want %h", digest, DIG_TWO); end
    checks++; if (rd_count != 64) begin errors++; $display("FAIL two_read_count: got %0d want 64", rd_count); end
  endtask

  task automatic test_rdy_stall();
    int de; logic b1;
    load_block(BLK_ABC);
    run_block(1'b1, 10, 40, 3, de, b1);
    checks++; if (de != 271) begin errors++; $display("FAIL stall_done_edge: got %0d want 271", de); end
    checks++; if (rd_low_rdy != 0) begin errors++; $display("FAIL stall_read_low: got %0d reads while rdy low want 0", rd_low_rdy); end
    checks++; if (rd_count != 64 || rd_bad_addr != 0) begin errors++; $display("FAIL stall_reads: got count=%0d bad=%0d want 64/0", rd_count, rd_bad_addr); end
    checks++; if (digest !== DIG_ABC) begin errors++; $display("FAIL stall_digest: got %h want %h", digest, DIG_ABC); end
  endtask

  task automatic test_reset_mid();
    int de; logic b1;
    load_block(BLK_ABC);
    clear_monitor();
    @(negedge clock);
    first_block = 1'b1;
    start       = 1'b1;
    @(posedge clock);
    repeat (122) @(posedge clock);
    #3;
    checks++; if (w_reg_addr !== 6'd30 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre_reset: got addr=%0d busy=%b want 30/1", w_reg_addr, busy); end
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || w_reg_read !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl: got busy=%b done=%b read=%b want 0/0/0", busy, done, w_reg_read); end
    checks++; if (w_reg_addr !== 6'd0) begin errors++; $display("FAIL mid_reset_addr: got %0d want 0", w_reg_addr); end
    checks++; if (digest !== 256'h0) begin errors++; $display("FAIL mid_reset_digest: got %h want 0", digest); end
    @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_hold: got busy=%b done=%b want 0/0", busy, done); end
    @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    #1;
    run_block(1'b1, 0, 0, 0, de, b1);
    checks++; if (digest !== DIG_ABC) begin errors++; $display("FAIL mid_rerun_digest: got %h want %h", digest, DIG_ABC); end
    checks++; if (de != 258) begin errors++; $display("FAIL mid_rerun_done_edge: got %0d want 258", de); end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_two_block();
    test_rdy_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sha256_round_core
`default_nettype wire

// File: doc/sha256_round_core.md
Name: sha256_round_core

Overview:
- Compression stage directly downstream of the W-schedule generator.
- Pulls W[0..63] one word at a time over the generator's read/address/ready handshake.
- Runs the 64 SHA-256 rounds on working registers a..h, then adds the result into the chaining state H0..H7 and presents the 256-bit digest.
- Supports a first block (initialised from the standard IV) and chained blocks (initialised from the previous digest).

Parameters:
- W_LAT, 2, cycles from a read pulse to valid w_reg_data; legal range 2..7.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level go; sampled in IDLE and DONE only.
- first_block  in  1  sampled with start. 1 = load IV into H; 0 = keep current H (chaining).
- w_reg_rdy  in  1  W generator is serving words.
- w_reg_data  in  32  W word returned by the generator.
- w_reg_read  out  1  one-cycle read pulse per W word.
- w_reg_addr  out  6  index of the W word requested; equals the round number.
- busy  out  1  high from LOAD through FINAL.
- done  out  1  high in DONE.
- digest  out  256  {H0..H7}, H0 in bits 255:224.

Behaviour:
- Reset (asynchronous, active-high): FSM goes to IDLE; a..h, H0..H7, round counter and wait counter clear to 0; all outputs are 0.
- IDLE: when start=1, go to LOAD.
- LOAD (1 cycle): if first_block=1, H <= IV and a..h <= IV; otherwise a..h <= H. Round counter <= 0. Go to REQ.
- REQ: if w_reg_rdy=0, stall with w_reg_read=0. If w_reg_rdy=1, drive w_reg_read=1 and w_reg_addr=round for exactly this one cycle, then go to WAIT.
  - Outside REQ, w_reg_read=0 and w_reg_addr holds its last value.
- WAIT: stay W_LAT cycles (counter), then go to ROUND.
- ROUND (1 cycle): T1 = h + Σ1(e) + Ch(e,f,g) + K[round] + w_reg_data; T2 = Σ0(a) + Maj(a,b,c). All additions mod 2^32.
  - Shift: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
  - If round=63, go to FINAL; otherwise round++ and go to REQ.
- FINAL (1 cycle): Hi <= Hi + working register i, mod 2^32 per word. Go to DONE.
- DONE: done=1. Stay while start=1; return to IDLE when start=0.
- digest is continuously {H0..H7}. It holds its value in IDLE/DONE and is updated only in LOAD (IV case) and FINAL.
- Latency with W_LAT=2 and w_reg_rdy steady high:
  - Each round takes W_LAT+2 = 4 cycles.
  - done rises 258 rising edges after the edge that samples start=1 in IDLE.
  - Each cycle w_reg_rdy is low in REQ adds one cycle.
- Exactly 64 read pulses per block, addresses 0..63 ascending, never repeated, never skipped.
- start=0 mid-block: ignored; the block always completes.
- start held high through DONE: no restart until start has been low for at least one cycle.
- Reset mid-block: immediate abort to IDLE with all state cleared. The chaining state is lost, so a multi-block message must restart with first_block=1.
- w_reg_rdy dropping during WAIT or ROUND: no effect on the word already requested.

Decomposition:
- Shared package sha256_pkg holds:
  - the eight IV words;
  - state encodings (IDLE, LOAD, REQ, WAIT, ROUND, FINAL, DONE).
- Sub-module sha256_k_rom: combinational 6-bit address to 32-bit K constant lookup, 64 entries. It is reusable by any future unrolled round variant.
- Σ0, Σ1, Ch and Maj stay as expressions inside the core.

Test Plan:
- Reset: assert reset asynchronously (mid-clock) -> done=0, busy=0, w_reg_read=0, w_reg_addr=0, digest=0 without waiting for a clock edge.
- Single-block "abc", first_block=1, paired with the W generator:
  - digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad;
  - done at edge 258;
  - exactly 64 w_reg_read pulses with addresses 0..63.
- Empty message, first_block=1 -> digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - block 1 with first_block=1, drop start, block 2 with first_block=0;
  - final digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Hold w_reg_rdy low for 10 cycles after LOAD, and for 3 cycles before round 40 -> no read pulse while low; done delayed by exactly 13 cycles; "abc" digest unchanged.
- Assert reset during round 30 -> IDLE on the next observation, outputs 0. A subsequent "abc" run with first_block=1 gives the correct digest.
